// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: round-robin, packet-locked N:1 AXI-Stream arbiter with a registered master stage.
//   clk, rst      : clock and synchronous active-high reset
//   s_tdata/s_tvalid/s_tlast/s_tready : N slave streams, input i in s_tdata[i*DW +: DW]
//   m_tdata/m_tvalid/m_tlast/m_tready : registered master stream
//   grant         : one-hot current owner, zero when idle
//   busy          : a packet is locked
//   trunc_err     : one-cycle pulse when a packet is cut at MAX_LEN beats
module axis_rr_arbiter #(
    parameter int N       = 4,
    parameter int DW      = 8,
    parameter int MAX_LEN = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N*DW-1:0] s_tdata,
    input  logic [N-1:0]  s_tvalid,
    input  logic [N-1:0]  s_tlast,
    output logic [N-1:0]  s_tready,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    output logic          m_tlast,
    input  logic          m_tready,
    output logic [N-1:0]  grant,
    output logic          busy,
    output logic          trunc_err
);
    localparam int IW = $clog2(N);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d, last_q, last_d, pick, idx;
    logic [N-1:0]  grant_q, grant_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [DW-1:0] m_tdata_q, m_tdata_d;
    logic          m_tvalid_q, m_tvalid_d, m_tlast_q, m_tlast_d, trunc_q, trunc_d;
    logic          found, ready, accept, trunc_now, end_pkt;
    // Rotating search starting just after the previous owner.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(last_q) + k) % N);
            if (!found && s_tvalid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end
    assign ready     = ~m_tvalid_q | m_tready;
    assign accept    = (state_q == LOCKED) && s_tvalid[owner_q] && ready;
    // The beat being accepted is number cnt_q+1; cutting at MAX_LEN.
    assign trunc_now = accept && !s_tlast[owner_q] && (cnt_q == 16'(MAX_LEN - 1));
    assign end_pkt   = accept && (s_tlast[owner_q] || trunc_now);
    assign s_tready  = (state_q == LOCKED && !rst) ? (grant_q & {N{ready}}) : '0;
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        trunc_d    = 1'b0;
        if (state_q == IDLE && found) begin
            state_d = LOCKED;
            owner_d = pick;
            grant_d = N'(1) << pick;
            cnt_d   = '0;
        end
        if (accept) begin
            m_tdata_d  = s_tdata[int'(owner_q)*DW +: DW];
            m_tvalid_d = 1'b1;
            m_tlast_d  = s_tlast[owner_q] | trunc_now;
            cnt_d      = cnt_q + 16'd1;
        end else if (m_tvalid_q && m_tready) begin
            m_tvalid_d = 1'b0;
        end
        if (end_pkt) begin
            state_d = IDLE;
            last_d  = owner_q;
            grant_d = '0;
            cnt_d   = '0;
            trunc_d = trunc_now;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            last_q     <= IW'(N - 1);
            grant_q    <= '0;
            cnt_q      <= '0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            trunc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            trunc_q    <= trunc_d;
        end
    end
    assign m_tdata   = m_tdata_q;
    assign m_tvalid  = m_tvalid_q;
    assign m_tlast   = m_tlast_q;
    assign grant     = grant_q;
    assign busy      = (state_q == LOCKED);
    assign trunc_err = trunc_q;
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: directed self-checking bench for axis_rr_arbiter (MAX_LEN=4).
module tb_axis_rr_arbiter;
    localparam int N = 4;
    localparam int DW = 8;
    logic          clk = 1'b0;
    logic          rst;
    logic [N*DW-1:0] s_tdata;
    logic [N-1:0]  s_tvalid, s_tlast, s_tready, grant;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid, m_tlast, m_tready, busy, trunc_err;
    int            checks = 0;
    int            errors = 0;
    int            rem[N], pos[N], plen[N];
    logic [7:0]    dat[N];
    logic [N-1:0]  hold;

    axis_rr_arbiter #(.N(N), .DW(DW), .MAX_LEN(4)) dut (
        .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(s_tready), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
        .m_tready(m_tready), .grant(grant), .busy(busy), .trunc_err(trunc_err)
    );

    always #5 clk = ~clk;

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            s_tvalid[i] = (rem[i] > 0) && !hold[i];
            s_tdata[i*DW +: DW] = dat[i];
            s_tlast[i] = ((pos[i] + 1) % plen[i]) == 0;
        end
    endtask

    task automatic tick();
        logic [N-1:0] hs;
        @(negedge clk);
        hs = s_tvalid & s_tready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (hs[i]) begin
                rem[i]--;
                pos[i]++;
                dat[i]++;
            end
        drive();
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; pos[i] = 0; plen[i] = 1; dat[i] = 8'h00;
        end
        hold = '0;
        m_tready = 1'b1;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_src();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_src();
        for (int i = 0; i < N; i++) rem[i] = 1;
        drive();
        #1;
        checks++;
        if (s_tready !== 4'b0000) begin errors++; $display("FAIL reset_tready got %b want 0000", s_tready); end
        tick();
        tick();
        checks++;
        if ({grant, busy, m_tvalid, m_tlast, m_tdata, trunc_err} !== 17'd0) begin
            errors++;
            $display("FAIL reset_state grant=%b busy=%b v=%b l=%b d=%h tr=%b want all zero",
                     grant, busy, m_tvalid, m_tlast, m_tdata, trunc_err);
        end
        clear_src();
        rst = 1'b0;
    endtask

    task automatic test_two_inputs();
        logic [3:0] eg[8];
        logic       ev[8];
        logic [7:0] ed[8];
        logic       el[8];
        eg = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0};
        ev = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        ed = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h12, 8'h20, 8'h21, 8'h22};
        el = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        rem[0] = 3; plen[0] = 3; dat[0] = 8'h10;
        rem[2] = 3; plen[2] = 3; dat[2] = 8'h20;
        drive();
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (grant !== eg[k] || m_tvalid !== ev[k]) begin
                errors++;
                $display("FAIL two_in_grant edge%0d got g=%b v=%b want g=%b v=%b", k + 1, grant, m_tvalid, eg[k], ev[k]);
            end
            if (ev[k]) begin
                checks++;
                if (m_tdata !== ed[k] || m_tlast !== el[k]) begin
                    errors++;
                    $display("FAIL two_in_data edge%0d got d=%h l=%b want d=%h l=%b", k + 1, m_tdata, m_tlast, ed[k], el[k]);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] eg[10];
        logic [7:0] ed[10];
        eg = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0};
        ed = '{8'h00, 8'h40, 8'h00, 8'h50, 8'h00, 8'h60, 8'h00, 8'h70, 8'h00, 8'h41};
        do_reset();
        for (int i = 0; i < N; i++) begin
            rem[i] = 2; plen[i] = 1; dat[i] = 8'(8'h40 + 8'h10 * i);
        end
        drive();
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (grant !== eg[k] || m_tvalid !== k[0]) begin
                errors++;
                $display("FAIL rr_grant edge%0d got g=%b v=%b want g=%b v=%b", k + 1, grant, m_tvalid, eg[k], k[0]);
            end
            if (k[0]) begin
                checks++;
                if (m_tdata !== ed[k] || m_tlast !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_data edge%0d got d=%h l=%b want d=%h l=1", k + 1, m_tdata, m_tlast, ed[k]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic       r[10];
        logic [3:0] er[10];
        logic       ev[10];
        logic [7:0] ed[10];
        r  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        er = '{4'h0, 4'h2, 4'h0, 4'h2, 4'h0, 4'h2, 4'h0, 4'h2, 4'h0, 4'h0};
        ev = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        ed = '{8'h00, 8'hA0, 8'hA0, 8'hA1, 8'hA1, 8'hA2, 8'hA2, 8'hA3, 8'hA3, 8'hA3};
        do_reset();
        rem[1] = 4; plen[1] = 4; dat[1] = 8'hA0;
        drive();
        for (int k = 0; k < 10; k++) begin
            m_tready = r[k];
            #1;
            checks++;
            if (s_tready !== er[k]) begin
                errors++;
                $display("FAIL bp_tready cycle%0d got %b want %b", k + 1, s_tready, er[k]);
            end
            tick();
            checks++;
            if (m_tvalid !== ev[k] || m_tdata !== ed[k] || (ev[k] && m_tlast !== (k == 7))) begin
                errors++;
                $display("FAIL bp_data edge%0d got v=%b d=%h l=%b want v=%b d=%h l=%b",
                         k + 1, m_tvalid, m_tdata, m_tlast, ev[k], ed[k], k == 7);
            end
        end
        m_tready = 1'b1;
    endtask

    task automatic test_truncation();
        logic [3:0] eg[8];
        logic       ev[8];
        logic [7:0] ed[8];
        logic       el[8];
        logic       et[8];
        eg = '{4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h8, 4'h8, 4'h0};
        ev = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        ed = '{8'h00, 8'h60, 8'h61, 8'h62, 8'h63, 8'h63, 8'h64, 8'h65};
        el = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        et = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        rem[3] = 6; plen[3] = 6; dat[3] = 8'h60;
        drive();
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (grant !== eg[k] || busy !== (eg[k] != 4'h0) || trunc_err !== et[k] || m_tvalid !== ev[k]) begin
                errors++;
                $display("FAIL trunc_ctrl edge%0d got g=%b busy=%b tr=%b v=%b want g=%b busy=%b tr=%b v=%b",
                         k + 1, grant, busy, trunc_err, m_tvalid, eg[k], eg[k] != 4'h0, et[k], ev[k]);
            end
            if (ev[k]) begin
                checks++;
                if (m_tdata !== ed[k] || m_tlast !== el[k]) begin
                    errors++;
                    $display("FAIL trunc_data edge%0d got d=%h l=%b want d=%h l=%b", k + 1, m_tdata, m_tlast, ed[k], el[k]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        rem[0] = 5; plen[0] = 5; dat[0] = 8'h70;
        rem[1] = 1; plen[1] = 1; dat[1] = 8'h80;
        drive();
        tick();
        checks++;
        if (grant !== 4'h1) begin errors++; $display("FAIL mrst_grant1 got %b want 0001", grant); end
        tick();
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 8'h70) begin
            errors++;
            $display("FAIL mrst_beat1 got v=%b d=%h want v=1 d=70", m_tvalid, m_tdata);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (s_tready !== 4'b0000) begin errors++; $display("FAIL mrst_tready got %b want 0000", s_tready); end
        tick();
        rst = 1'b0;
        checks++;
        if (m_tvalid !== 1'b0 || grant !== 4'h0 || busy !== 1'b0 || m_tdata !== 8'h00 || m_tlast !== 1'b0) begin
            errors++;
            $display("FAIL mrst_state got v=%b g=%b busy=%b d=%h l=%b want v=0 g=0000 busy=0 d=00 l=0",
                     m_tvalid, grant, busy, m_tdata, m_tlast);
        end
        tick();
        checks++;
        if (grant !== 4'h1) begin errors++; $display("FAIL mrst_regrant got %b want 0001", grant); end
        tick();
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 8'h71) begin
            errors++;
            $display("FAIL mrst_resume got v=%b d=%h want v=1 d=71", m_tvalid, m_tdata);
        end
    endtask

    task automatic test_owner_drop();
        logic [3:0] eg[9];
        eg = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h1, 4'h0};
        do_reset();
        rem[1] = 3; plen[1] = 3; dat[1] = 8'h90;
        drive();
        for (int k = 0; k < 9; k++) begin
            if (k == 1) rem[0] = 1;
            dat[0] = (k == 1) ? 8'h05 : dat[0];
            hold[1] = (k >= 2 && k <= 4);
            drive();
            tick();
            checks++;
            if (grant !== eg[k]) begin
                errors++;
                $display("FAIL drop_grant edge%0d got %b want %b", k + 1, grant, eg[k]);
            end
            if (k == 3 || k == 5 || k == 6 || k == 8) begin
                checks++;
                if (m_tvalid !== (k != 3) || (k != 3 && m_tdata !== (k == 5 ? 8'h91 : k == 6 ? 8'h92 : 8'h05))) begin
                    errors++;
                    $display("FAIL drop_data edge%0d got v=%b d=%h want v=%b d=%h", k + 1, m_tvalid, m_tdata,
                             k != 3, k == 5 ? 8'h91 : k == 6 ? 8'h92 : 8'h05);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        hold = '0;
        m_tready = 1'b1;
        clear_src();
        test_reset();
        test_two_inputs();
        test_round_robin();
        test_backpressure();
        test_truncation();
        test_mid_reset();
        test_owner_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axis_rr_arbiter.md
AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
REQ-001 Parameter N, default 4, number of AXI-Stream slave inputs (2..8).
REQ-002 Parameter DW, default 8, tdata width in bits.
REQ-003 Parameter MAX_LEN, default 256, maximum beats per granted packet (2..65535).
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 s_tdata  input  N*DW  slave data; input i occupies bits [i*DW +: DW].
REQ-007 s_tvalid  input  N  per-input valid.
REQ-008 s_tlast  input  N  per-input end-of-packet.
REQ-009 s_tready  output  N  per-input ready.
REQ-010 m_tdata  output  DW  master data, registered.
REQ-011 m_tvalid  output  1  master valid, registered.
REQ-012 m_tlast  output  1  master end-of-packet, registered.
REQ-013 m_tready  input  1  master ready.
REQ-014 grant  output  N  one-hot owner of the output; all-zero when idle; registered.
REQ-015 busy  output  1  high while a packet is locked.
REQ-016 trunc_err  output  1  one-cycle pulse on a forced truncation.

Function
REQ-017 Two-state FSM: IDLE (no owner) and LOCKED (one owner, packet in flight).
REQ-018 IDLE: when any s_tvalid is high, the arbiter selects the first requesting input at or after (last_owner+1) mod N, sets grant to it and enters LOCKED on the next edge.
REQ-019 IDLE with no s_tvalid high: remain IDLE; grant=0; all s_tready=0.
REQ-020 LOCKED: s_tready[g]=(~m_tvalid | m_tready) combinationally for owner g; s_tready of every other input is 0.
REQ-021 Beat acceptance on owner (s_tvalid[g] & s_tready[g]) loads m_tdata/m_tlast from input g and sets m_tvalid=1 on the next edge.
REQ-022 m_tvalid clears on the edge where m_tvalid & m_tready and no new beat is accepted; m_tdata holds its last value.
REQ-023 Master output never changes while m_tvalid=1 and m_tready=0.
REQ-024 Latency: s_tvalid rising in IDLE at cycle t -> grant at t+1 -> first beat on m_tvalid at t+2 (m_tready=1 throughout); thereafter one beat per cycle.
REQ-025 Accepting a beat with s_tlast[g]=1 returns the FSM to IDLE on the same edge; last_owner<=g; grant<=0.
REQ-026 A 16-bit beat counter increments on every accepted beat in LOCKED and clears on entry to IDLE.
REQ-027 If the accepted beat is beat number MAX_LEN and s_tlast[g]=0, m_tlast is forced to 1, trunc_err pulses for one cycle, and the FSM returns to IDLE as in REQ-025; the owner's remaining beats are arbitrated as a new packet.
REQ-028 Owner dropping s_tvalid mid-packet keeps the lock; no other input is granted until the owner's tlast beat or truncation.
REQ-029 A single requester is re-granted after each packet with one IDLE cycle between packets.
REQ-030 Inputs not owning the grant are never sampled; their tdata/tlast have no effect.

Reset
REQ-031 On rst: FSM=IDLE, grant=0, busy=0, m_tvalid=0, m_tlast=0, m_tdata=0, trunc_err=0, beat counter=0, last_owner=N-1 (input 0 has first priority).
REQ-032 rst asserted mid-packet abandons the packet: outputs return to REQ-031 values on that edge; s_tready=0 during rst; no partial-packet state survives.

Verification
REQ-033 Inputs 0 and 2 request together after reset, 3-beat packets, m_tready=1 -> input 0's 3 beats then input 2's 3 beats; grant 0001, 0000, 0100.
REQ-034 All 4 inputs continuously request 1-beat packets -> owner order 0,1,2,3,0; one IDLE cycle between packets.
REQ-035 Input 1 sending 4 beats with m_tready low every other cycle -> m_tdata stable while stalled; beats 0xA0..0xA3 in order; no loss or duplication.
REQ-036 MAX_LEN=4, input 3 sending 6 beats without tlast until beat 6 -> m_tlast on beat 4, trunc_err pulse, beats 5-6 as a new granted packet.
REQ-037 rst pulsed during beat 2 of a 5-beat packet from input 0 -> next cycle m_tvalid=0, grant=0, busy=0; after release input 0 is granted first.
REQ-038 Input 1 locked, input 0 requesting, input 1 dropping s_tvalid for 3 cycles mid-packet -> grant stays 0010; input 0 granted only after input 1's tlast.
